// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter slice.
//   tx_state_t    - transmitter FSM state encoding
//   PARITY_*      - parity-mode constants for the PARITY parameter
//   frame_len()   - frame length in clk cycles for a given configuration
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic int frame_len(input int data_bits, input int parity,
                                   input int stop_bits, input int clks_per_bit);
    return (1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous show-ahead FIFO used as the transmit word buffer.
// Pointers carry one extra MSB so full and empty are distinguished on wrap.
// Ports:
//   clk, reset       - rising-edge clock, asynchronous active-high reset
//   wr_en, wr_data   - push (taken when not full, or when popping the same cycle)
//   rd_en            - pop (taken when not empty)
//   rd_data          - head word, valid while !empty
//   full, empty      - occupancy flags
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];
  // A push into a full FIFO is legal when the head is popped on the same edge.
  assign do_wr   = wr_en && (!full || rd_en);
  assign do_rd   = rd_en && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits, each held for CLKS_PER_BIT cycles.
// Build option: define UART_TX_FIFO_EN to buffer words in a FIFO_DEPTH-entry
// FIFO (uart_tx_fifo); otherwise a single holding register is used.
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-high reset
//   e_i      - write strobe
//   d_i      - payload, taken when e_i && ready_o
//   ready_o  - a write is accepted this cycle
//   tx_o     - registered serial line, idles high
//   busy_o   - registered, high while a frame is on the line
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 e_i,
  input  logic [DATA_BITS-1:0] d_i,
  output logic                 ready_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam int IW = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_tx_cfg: illegal parameter combination");
  end

  tx_state_t            state;
  logic [TW-1:0]        timer;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  logic                 bit_end;
  logic                 frame_end;
  logic                 launch;
  logic                 wr_acc;
  logic                 bypass;
  logic                 push;
  logic                 pop;
  logic                 start_next;
  logic                 store_empty;
  logic                 store_full;
  logic [DATA_BITS-1:0] store_head;
  logic [DATA_BITS-1:0] next_word;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] w);
    return (PARITY == PARITY_EVEN) ? ^w : ~^w;
  endfunction

  // A new frame can be launched when idle or on the last stop cycle. The
  // oldest stored word goes first; with storage empty, an incoming write
  // bypasses storage so the start bit follows the write by one cycle.
  assign bit_end    = (timer == TW'(CLKS_PER_BIT - 1));
  assign frame_end  = (state == S_STOP) && bit_end && (bit_idx == IW'(STOP_BITS - 1));
  assign launch     = (state == S_IDLE) || frame_end;
  assign ready_o    = !store_full || (launch && !store_empty);
  assign wr_acc     = e_i && ready_o;
  assign bypass     = launch && store_empty && wr_acc;
  assign push       = wr_acc && !bypass;
  assign pop        = launch && !store_empty;
  assign start_next = pop || bypass;
  assign next_word  = store_empty ? d_i : store_head;

`ifdef UART_TX_FIFO_EN
  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (d_i),
    .rd_en   (pop),
    .rd_data (store_head),
    .full    (store_full),
    .empty   (store_empty)
  );
`else
  logic                 hold_valid;
  logic [DATA_BITS-1:0] hold_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_data  <= d_i;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign store_empty = !hold_valid;
  assign store_full  = hold_valid;
  assign store_head  = hold_data;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tx_o    <= 1'b1;
      busy_o  <= 1'b0;
    end else begin
      if (state != S_IDLE) timer <= bit_end ? '0 : timer + TW'(1);
      unique case (state)
        S_IDLE: begin
          if (start_next) begin
            state   <= S_START;
            shreg   <= next_word;
            par_bit <= calc_parity(next_word);
            tx_o    <= 1'b0;
            busy_o  <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            bit_idx <= '0;
            tx_o    <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == IW'(DATA_BITS - 1)) begin
              bit_idx <= '0;
              if (PARITY != PARITY_NONE) begin
                state <= S_PARITY;
                tx_o  <= par_bit;
              end else begin
                state <= S_STOP;
                tx_o  <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + IW'(1);
              tx_o    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state <= S_STOP;
            tx_o  <= 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (bit_idx != IW'(STOP_BITS - 1)) begin
              bit_idx <= bit_idx + IW'(1);
            end else if (start_next) begin
              state   <= S_START;
              bit_idx <= '0;
              shreg   <= next_word;
              par_bit <= calc_parity(next_word);
              tx_o    <= 1'b0;
            end else begin
              state   <= S_IDLE;
              bit_idx <= '0;
              tx_o    <= 1'b1;
              busy_o  <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: self-checking bench for uart_tx_cfg. Three instances cover
// 8E1, 8O1 and 7N2 framing; a frame-level reference model (word queue plus
// position within the current frame) checks the 8E1 instance under directed
// and random write traffic.
module tb_uart_tx_cfg;

  localparam int CPB = 4;
`ifdef UART_TX_FIFO_EN
  localparam int STORE = 4;
`else
  localparam int STORE = 1;
`endif
  localparam int FL_EV = (1 + 8 + 1 + 1) * CPB;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       e_ev = 1'b0, e_od = 1'b0, e_72 = 1'b0;
  logic [7:0] d_ev = '0, d_od = '0;
  logic [6:0] d_72 = '0;
  logic       rdy_ev, tx_ev, busy_ev;
  logic       rdy_od, tx_od, busy_od;
  logic       rdy_72, tx_72, busy_72;

  int total = 0;
  int bad   = 0;

  logic cap_tx   [256];
  logic cap_busy [256];

  // reference model state for the 8E1 instance
  int         m_pos = -1;
  logic [7:0] m_cur = '0;
  logic [7:0] m_pend[$];

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_even (
    .clk(clk), .reset(reset), .e_i(e_ev), .d_i(d_ev), .ready_o(rdy_ev), .tx_o(tx_ev), .busy_o(busy_ev));
  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_odd (
    .clk(clk), .reset(reset), .e_i(e_od), .d_i(d_od), .ready_o(rdy_od), .tx_o(tx_od), .busy_o(busy_od));
  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
    .clk(clk), .reset(reset), .e_i(e_72), .d_i(d_72), .ready_o(rdy_72), .tx_o(tx_72), .busy_o(busy_72));

  // Bit k of a frame: 0 start, 1..db data LSB first, then parity, then stop bits.
  function automatic logic exp_bit(input logic [8:0] d, input int db, input int par, input int k);
    logic x;
    x = 1'b0;
    for (int i = 0; i < db; i++) x = x ^ d[i];
    if (k == 0) return 1'b0;
    if (k <= db) return d[k-1];
    if (par != 0 && k == db + 1) return (par == 2) ? x : ~x;
    return 1'b1;
  endfunction

  function automatic logic [2:0] outs(input int sel);
    case (sel)
      0:       return {tx_ev, busy_ev, rdy_ev};
      1:       return {tx_od, busy_od, rdy_od};
      default: return {tx_72, busy_72, rdy_72};
    endcase
  endfunction

  task automatic drive(input int sel, input logic e, input logic [8:0] d);
    case (sel)
      0:       begin e_ev = e; d_ev = d[7:0]; end
      1:       begin e_od = e; d_od = d[7:0]; end
      default: begin e_72 = e; d_72 = d[6:0]; end
    endcase
  endtask

  // Single write from idle, then record tx/busy for n cycles from frame cycle 0.
  task automatic capture(input int sel, input logic [8:0] d, input int n);
    logic [2:0] o;
    @(negedge clk);
    drive(sel, 1'b1, d);
    @(negedge clk);
    drive(sel, 1'b0, 9'h000);
    for (int c = 0; c < n; c++) begin
      o = outs(sel);
      cap_tx[c]   = o[2];
      cap_busy[c] = o[1];
      @(negedge clk);
    end
  endtask

  function automatic logic m_launch();
    return (m_pos < 0) || (m_pos == FL_EV - 1);
  endfunction

  function automatic logic m_ready();
    return (m_pend.size() < STORE) || (m_launch() && m_pend.size() > 0);
  endfunction

  function automatic logic m_tx();
    return (m_pos < 0) ? 1'b1 : exp_bit({1'b0, m_cur}, 8, 2, m_pos / CPB);
  endfunction

  task automatic m_step(input logic e, input logic [7:0] d);
    logic       acc, go;
    logic [7:0] nw;
    acc = e && m_ready();
    go  = 1'b0;
    nw  = '0;
    if (m_launch() && m_pend.size() > 0) begin
      nw = m_pend.pop_front();
      go = 1'b1;
      if (acc) m_pend.push_back(d);
    end else if (m_launch() && acc) begin
      nw = d;
      go = 1'b1;
    end else if (acc) begin
      m_pend.push_back(d);
    end
    if (go) begin
      m_cur = nw;
      m_pos = 0;
    end else if (m_pos >= 0) begin
      m_pos = (m_pos == FL_EV - 1) ? -1 : m_pos + 1;
    end
  endtask

  task automatic quiesce();
    e_ev = 1'b0; e_od = 1'b0; e_72 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_pos = -1;
    m_pend.delete();
  endtask

  task automatic test_reset();
    logic [2:0] o;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      o = outs(s);
      total++;
      if (o !== 3'b101) begin
        bad++;
        $display("FAIL reset_state inst=%0d tx,busy,ready=%b want 101", s, o);
      end
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame(input int sel, input logic [8:0] d, input int db, input int par,
                            input int sb, input string name);
    int   fl, hi, n;
    logic etx;
    fl = (1 + db + ((par != 0) ? 1 : 0) + sb) * CPB;
    n  = fl + 12;
    hi = 0;
    capture(sel, d, n);
    for (int c = 0; c < n; c++) begin
      etx = (c < fl) ? exp_bit(d, db, par, c / CPB) : 1'b1;
      total++;
      if (cap_tx[c] !== etx || cap_busy[c] !== (c < fl)) begin
        bad++;
        $display("FAIL %s cycle %0d tx=%b busy=%b want tx=%b busy=%b", name, c, cap_tx[c],
                 cap_busy[c], etx, (c < fl));
      end
      if (cap_busy[c] === 1'b1) hi++;
    end
    total++;
    if (hi != fl) begin
      bad++;
      $display("FAIL %s_busy_len got %0d want %0d", name, hi, fl);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [4];
    logic [2:0] o, ex;
    int         hi, exp_hi, n;
    words  = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_hi = ((STORE + 1 < 4) ? STORE + 1 : 4) * FL_EV;
    n      = 4 * FL_EV + 30;
    hi     = 0;
    quiesce();
    for (int c = 0; c < n; c++) begin
      o  = {tx_ev, busy_ev, rdy_ev};
      ex = {m_tx(), (m_pos >= 0), m_ready()};
      total++;
      if (o !== ex) begin
        bad++;
        $display("FAIL back_to_back cycle %0d tx,busy,ready=%b want %b", c, o, ex);
      end
      if (busy_ev === 1'b1) hi++;
      e_ev = (c < 4);
      d_ev = (c < 4) ? words[c] : 8'h00;
      m_step(e_ev, d_ev);
      @(negedge clk);
    end
    total++;
    if (hi != exp_hi) begin
      bad++;
      $display("FAIL back_to_back_busy_len got %0d want %0d", hi, exp_hi);
    end
  endtask

  task automatic test_fill_while_busy();
    logic [2:0] o, ex;
    int         n;
    n = (STORE + 1) * FL_EV + 20;
    quiesce();
    for (int c = 0; c < n; c++) begin
      o  = {tx_ev, busy_ev, rdy_ev};
      ex = {m_tx(), (m_pos >= 0), m_ready()};
      total++;
      if (o !== ex) begin
        bad++;
        $display("FAIL fill cycle %0d tx,busy,ready=%b want %b", c, o, ex);
      end
      if (c == 8) begin
        total++;
        if (rdy_ev !== 1'b0) begin
          bad++;
          $display("FAIL fill_full_ready got %b want 0", rdy_ev);
        end
      end
      e_ev = (c <= 8);
      d_ev = (c < 8) ? 8'(c + 1) : 8'hEE;
      m_step(e_ev, d_ev);
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [2:0] o, ex;
    int         n;
    n = 600 + (STORE + 2) * FL_EV;
    quiesce();
    for (int c = 0; c < n; c++) begin
      o  = {tx_ev, busy_ev, rdy_ev};
      ex = {m_tx(), (m_pos >= 0), m_ready()};
      total++;
      if (o !== ex) begin
        bad++;
        $display("FAIL random cycle %0d tx,busy,ready=%b want %b", c, o, ex);
      end
      e_ev = (c < 600) && ($urandom_range(0, 99) < 30);
      d_ev = 8'($urandom);
      m_step(e_ev, d_ev);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [2:0] o;
    quiesce();
    e_ev = 1'b1; d_ev = 8'hA5;
    @(negedge clk);
    e_ev = 1'b1; d_ev = 8'h3C;
    @(negedge clk);
    e_ev = 1'b0;
    repeat (9) @(negedge clk);
    total++;
    if ({tx_ev, busy_ev} !== {exp_bit(9'h0A5, 8, 2, 10 / CPB), 1'b1}) begin
      bad++;
      $display("FAIL pre_reset tx,busy=%b%b want %b1", tx_ev, busy_ev, exp_bit(9'h0A5, 8, 2, 10 / CPB));
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({tx_ev, busy_ev, rdy_ev} !== 3'b101) begin
      bad++;
      $display("FAIL reset_async tx,busy,ready=%b%b%b want 101", tx_ev, busy_ev, rdy_ev);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 120; c++) begin
      o = {tx_ev, busy_ev, rdy_ev};
      total++;
      if (o !== 3'b101) begin
        bad++;
        $display("FAIL after_reset cycle %0d tx,busy,ready=%b want 101", c, o);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_frame(0, 9'h0A5, 8, 2, 1, "even_a5");
    test_frame(1, 9'h0A5, 8, 1, 1, "odd_a5");
    test_frame(2, 9'h041, 7, 0, 2, "7n2_41");
    test_back_to_back();
    test_fill_while_busy();
    test_random();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4: clk cycles per serial bit, legal range >= 2.
REQ-002 SHALL have parameter DATA_BITS, default 8: payload bits per frame, legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits per frame, legal values 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: power of two >= 2; used only when UART_TX_FIFO_EN is defined.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port e_i, input, 1 bit: write strobe.
REQ-009 SHALL have port d_i, input, DATA_BITS bits: payload, sampled when e_i && ready_o.
REQ-010 SHALL have port ready_o, output, 1 bit: high when a write is accepted this cycle.
REQ-011 SHALL have port tx_o, output, 1 bit: serial line, driven from a register, idles high.
REQ-012 SHALL have port busy_o, output, 1 bit: high while a frame is on the line.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY and STOP.
REQ-014 SHALL sequence the states IDLE->START->DATA->(PARITY if PARITY!=0)->STOP->(START if a word is pending, else IDLE).
REQ-015 SHALL hold every bit (start, data, parity, each stop bit) on tx_o for exactly CLKS_PER_BIT cycles.
REQ-016 SHALL make the frame length (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
REQ-017 SHALL transmit data LSB first.
REQ-018 SHALL compute the parity bit over the DATA_BITS payload bits: even mode gives XOR, odd mode gives ~XOR.
REQ-019 SHALL drive tx_o low (start bit) on the cycle after a write that is accepted while in IDLE with no word pending: latency 1.
REQ-020 SHALL begin the next START on the cycle after the last STOP cycle, with no idle gap, when a word is pending.
REQ-021 SHALL assert busy_o from the first START cycle through the last STOP cycle, and deassert it in IDLE.
REQ-022 SHALL size the bit timer to $clog2(CLKS_PER_BIT)+1 bits, and the bit index to $clog2(DATA_BITS) bits.
REQ-023 SHALL silently drop a write while ready_o is low, with no state change.
REQ-024 SHALL accept a write on the same cycle that the stored word is consumed.

Reset
REQ-025 SHALL, while reset is high, force tx_o=1, busy_o=0 and ready_o=1, state IDLE, timer and bit index 0, and storage empty, independent of clk.
REQ-026 SHALL, on reset mid-frame, truncate the frame immediately and not transmit the interrupted word or any pending word after release.

Configuration
REQ-027 SHALL, with UART_TX_FIFO_EN defined, buffer words in a FIFO_DEPTH-entry FIFO; ready_o = !full.
REQ-028 SHALL, with UART_TX_FIFO_EN undefined, buffer words in a single holding register; ready_o = holding register empty.
REQ-029 SHALL keep the serial timing identical in both builds.

Structure
REQ-030 SHALL place the FSM state encoding, the parity-mode constants (PARITY_NONE/ODD/EVEN) and the frame-length function in a shared package, uart_pkg.
REQ-031 SHALL implement the FIFO as sub-module uart_tx_fifo: synchronous write and read, full and empty flags, wrap-around pointers with an extra MSB.

Verification
REQ-032 SHALL verify: CLKS_PER_BIT=4, DATA_BITS=8, PARITY=2, write 0xA5 -> tx_o = 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles; frame 44 cycles; busy_o high for 44 cycles.
REQ-033 SHALL verify: same build with PARITY=1, write 0xA5 -> parity bit 1.
REQ-034 SHALL verify: PARITY=0, DATA_BITS=7, STOP_BITS=2, write 0x41 -> tx_o = 0,1,0,0,0,0,0,1,1,1; frame 40 cycles.
REQ-035 SHALL verify: FIFO build with FIFO_DEPTH=4, write 0x11/0x22/0x33/0x44 on consecutive cycles -> four contiguous frames; busy_o high for 176 cycles; no high gap between frames beyond the stop bits.
REQ-036 SHALL verify: FIFO build, keep writing while busy -> ready_o low after the FIFO fills; an extra write of 0xEE while full never appears on tx_o.
REQ-037 SHALL verify: assert reset on cycle 10 of a frame -> tx_o=1 and busy_o=0 immediately; no further frame after release.
